// File: rtl/pattern_fsm_tick_pkg.sv
// Shared types for the tick-sampled pattern detector.
// The package holds the FSM state encoding and the width helper for the fill counter.
package pattern_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    HIT   = 2'd3
  } state_t;

  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/pattern_fsm_tick_if.sv
// Control and status bundle of the pattern detector.
// The board-side driver uses the master modport and the detector uses the slave modport.
interface pattern_fsm_tick_if
  import pattern_fsm_pkg::*;
#(
  parameter int PAT_LEN   = 4,
  parameter int CNT_WIDTH = 8
);

  localparam int FILL_W = fill_width(PAT_LEN);

  logic                 en;
  logic                 x;
  logic                 cnt_clr;
  logic                 tick;
  logic [1:0]           state;
  logic [FILL_W-1:0]    fill;
  logic                 z1;
  logic                 z2;
  logic [CNT_WIDTH-1:0] match_cnt;
  logic                 cnt_sat;

  modport master (
    output en, x, cnt_clr,
    input  tick, state, fill, z1, z2, match_cnt, cnt_sat
  );

  modport slave (
    input  en, x, cnt_clr,
    output tick, state, fill, z1, z2, match_cnt, cnt_sat
  );

endinterface

// File: rtl/pattern_fsm_tick_tick_gen.sv
// Free-running prescaler that emits a one-cycle sample enable every DIV_MAX+1 clocks.
// Replaces the old divided-clock blocks so that everything downstream stays on one clock.
module tick_gen #(
  parameter int DIV_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(DIV_MAX)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DW'(DIV_MAX));

endmodule

// File: rtl/pattern_fsm_tick.sv
// Tick-sampled serial pattern detector with Moore/Mealy outputs and a saturating match counter.
// Samples x once per prescaler tick; overlapping or non-overlapping detection is set by OVERLAP.
module pattern_fsm_tick
  import pattern_fsm_pkg::*;
#(
  parameter int                 DIV_MAX   = 3,
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1101,
  parameter int                 OVERLAP   = 1,
  parameter int                 CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  pattern_fsm_tick_if.slave bus
);

  localparam int FILL_W = fill_width(PAT_LEN);

  state_t               state_q, state_d;
  // The oldest sample only matters in the compare, so only PAT_LEN-1 bits are kept.
  logic [PAT_LEN-2:0]   hist_q, hist_d;
  logic [PAT_LEN-1:0]   hist_n;
  logic [FILL_W-1:0]    fill_q, fill_d, fill_n;
  logic                 full_n;
  logic                 tick;
  logic                 match;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 sat;

  tick_gen #(.DIV_MAX(DIV_MAX)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign hist_n = {hist_q, bus.x};
  assign fill_n = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
  assign full_n = (fill_n == FILL_W'(PAT_LEN));
  assign match  = tick & bus.en & full_n & (hist_n == PATTERN);
  assign sat    = &cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (!bus.en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else if (tick) begin
      if (match) begin
        state_d = HIT;
        if (OVERLAP != 0) begin
          hist_d = hist_n[PAT_LEN-2:0];
          fill_d = fill_n;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = hist_n[PAT_LEN-2:0];
        fill_d = fill_n;
        // Non-overlapping HIT restarts from an empty history, so it behaves like FILL.
        if (state_q == ARMED || (state_q == HIT && OVERLAP != 0)) begin
          state_d = ARMED;
        end else begin
          state_d = full_n ? ARMED : FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (match && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.tick      = tick;
  assign bus.state     = state_q;
  assign bus.fill      = fill_q;
  assign bus.z1        = (state_q == HIT);
  assign bus.z2        = match;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat;

endmodule

// File: tb/tb_pattern_fsm_tick.sv
// Directed bench for pattern_fsm_tick: overlapping, non-overlapping and saturating builds side by side.
// Vectors carry hand-computed expectations; corner cases are hand-written sequences.
module tb_pattern_fsm_tick;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pattern_fsm_tick_if #(.PAT_LEN(4), .CNT_WIDTH(8)) if_a ();
  pattern_fsm_tick_if #(.PAT_LEN(4), .CNT_WIDTH(8)) if_b ();
  pattern_fsm_tick_if #(.PAT_LEN(4), .CNT_WIDTH(2)) if_c ();

  pattern_fsm_tick #(.DIV_MAX(3), .PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_WIDTH(8))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  pattern_fsm_tick #(.DIV_MAX(3), .PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_WIDTH(8))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  pattern_fsm_tick #(.DIV_MAX(0), .PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_WIDTH(2))
    dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  typedef struct {
    logic       x;
    logic       a_z2;
    logic [1:0] a_state;
    logic       b_z2;
    logic [1:0] b_state;
    logic [2:0] b_fill;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Leaves the bench at the falling edge of the next tick cycle of the DIV_MAX=3 builds.
  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!if_a.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!if_a.tick) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_timeout: actual=0 required=1");
    end
  endtask

  task automatic feed_a(input logic xv, input logic exp_z2, input string name);
    if_a.x = xv;
    wait_tick();
    check(name, if_a.z2, exp_z2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] c_bits;

    vecs[0] = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 3'd1};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 3'd2};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 3'd3};
    vecs[3] = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd3, 3'd0};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 3'd1};
    vecs[5] = '{1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 3'd2};
    vecs[6] = '{1'b1, 1'b1, 2'd3, 1'b0, 2'd1, 3'd3};

    if_a.en = 1'b0; if_a.x = 1'b0; if_a.cnt_clr = 1'b0;
    if_b.en = 1'b0; if_b.x = 1'b0; if_b.cnt_clr = 1'b0;
    if_c.en = 1'b0; if_c.x = 1'b0; if_c.cnt_clr = 1'b0;

    #17;
    check("rst_tick", if_a.tick, 0);
    check("rst_state", if_a.state, 0);
    check("rst_fill", if_a.fill, 0);
    check("rst_z1", if_a.z1, 0);
    check("rst_z2", if_a.z2, 0);
    check("rst_cnt", if_a.match_cnt, 0);
    check("rst_sat", if_a.cnt_sat, 0);
    #1 reset = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("presc_tick[%0d]", k), if_a.tick, (k % 4 == 0) ? 1 : 0);
      check($sformatf("div0_tick[%0d]", k), if_c.tick, 1);
    end
    @(posedge clk);
    #1;

    if_a.en = 1'b1;
    if_b.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if_a.x = vecs[i].x;
      if_b.x = vecs[i].x;
      wait_tick();
      check($sformatf("a_z2[%0d]", i), if_a.z2, vecs[i].a_z2);
      check($sformatf("b_z2[%0d]", i), if_b.z2, vecs[i].b_z2);
      @(posedge clk);
      #1;
      check($sformatf("a_state[%0d]", i), if_a.state, vecs[i].a_state);
      check($sformatf("a_z1[%0d]", i), if_a.z1, (vecs[i].a_state == 2'd3) ? 1 : 0);
      check($sformatf("b_state[%0d]", i), if_b.state, vecs[i].b_state);
      check($sformatf("b_fill[%0d]", i), if_b.fill, vecs[i].b_fill);
    end
    check("a_cnt_overlap", if_a.match_cnt, 2);
    check("b_cnt_nonoverlap", if_b.match_cnt, 1);
    check("a_sat_low", if_a.cnt_sat, 0);
    if_b.en = 1'b0;

    if_a.en = 1'b0;
    @(posedge clk);
    #1;
    check("endrop_idle", if_a.state, 0);
    check("endrop_cnt_kept", if_a.match_cnt, 2);
    if_a.en = 1'b1;
    @(posedge clk);
    #1;
    feed_a(1'b1, 1'b0, "en_pre0");
    feed_a(1'b1, 1'b0, "en_pre1");
    feed_a(1'b0, 1'b0, "en_pre2");
    check("en_pre_fill", if_a.fill, 3);
    if_a.en = 1'b0;
    @(posedge clk);
    #1;
    check("en_off_state", if_a.state, 0);
    check("en_off_fill", if_a.fill, 0);
    if_a.en = 1'b1;
    @(posedge clk);
    #1;
    check("en_back_state", if_a.state, 1);
    feed_a(1'b1, 1'b0, "en_fresh0");
    check("en_fresh_fill", if_a.fill, 1);
    feed_a(1'b1, 1'b0, "en_fresh1");
    feed_a(1'b0, 1'b0, "en_fresh2");
    feed_a(1'b1, 1'b1, "en_fresh3");
    check("en_hit_state", if_a.state, 3);
    check("en_hit_cnt", if_a.match_cnt, 3);
    check("en_hit_z1", if_a.z1, 1);

    #2 reset = 1'b1;
    #1;
    check("arst_state", if_a.state, 0);
    check("arst_z1", if_a.z1, 0);
    check("arst_fill", if_a.fill, 0);
    check("arst_cnt", if_a.match_cnt, 0);
    check("arst_tick", if_a.tick, 0);
    #2 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("arst_tick_edge%0d", k), if_a.tick, (k == 3) ? 1 : 0);
    end

    @(posedge clk);
    #1;
    if_c.en = 1'b1;
    @(posedge clk);
    #1;
    c_bits = 16'b1101101101101101;
    for (int i = 0; i < 16; i++) begin
      if_c.x = c_bits[15-i];
      @(negedge clk);
      check($sformatf("c_z2[%0d]", i), if_c.z2, (i >= 3 && i % 3 == 0) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    check("c_cnt_sat_val", if_c.match_cnt, 3);
    check("c_sat_flag", if_c.cnt_sat, 1);

    if_c.x = 1'b1;
    @(posedge clk);
    #1;
    if_c.x = 1'b0;
    @(posedge clk);
    #1;
    if_c.x = 1'b1;
    if_c.cnt_clr = 1'b1;
    @(negedge clk);
    check("c_clr_z2", if_c.z2, 1);
    @(posedge clk);
    #1;
    if_c.cnt_clr = 1'b0;
    check("c_clr_cnt", if_c.match_cnt, 0);
    check("c_clr_sat", if_c.cnt_sat, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
